id_stage: RTL and testbench

- Single-entry pipelined RV32I instruction-decode stage that drives the execute-stage ALU.
- Takes one fetched instruction and PC per handshake and reads two register-file ports combinationally.
- Registers the ALU operation code, ALU operands, writeback/memory/control flags and immediate towards execute.
- Sits between fetch and execute in core_v1. It is the producer of the ALU's alu_ctrl/data_x/data_y interface.

---
 rtl/core_pkg.sv | 69 ++++++
 rtl/imm_gen.sv | 30 +++
 rtl/id_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core_v1 definitions. Holds the ALU operation codes
//               (shared with the execute-stage ALU), the RV32I base opcodes,
//               the decoded-instruction record carried from decode to
//               execute, and the funct3 to ALU-op helper for OP/OP-IMM.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN_C = 32;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Decoded fields that depend on the instruction class
    typedef struct packed {
        logic [3:0]        alu_ctrl;
        logic [XLEN_C-1:0] data_x;
        logic [XLEN_C-1:0] data_y;
        logic [XLEN_C-1:0] imm;
        logic [XLEN_C-1:0] store_data;
        logic              we;
        logic              mem_rd;
        logic              mem_wr;
        logic              branch;
        logic              jump;
        logic              illegal;
    } dec_t;

    // Base funct3 mapping shared by OP (funct7=0) and OP-IMM
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32I immediate generator. All immediates are
//               sign-extended from instr[31].
// Ports       : instr  in  [31:7] instruction word (opcode bits not needed)
//               imm_i  out 32     I-type immediate
//               imm_s  out 32     S-type immediate
//               imm_b  out 32     B-type immediate
//               imm_u  out 32     U-type immediate
//               imm_j  out 32     J-type immediate
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen (
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_s,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : Single-entry RV32I decode stage. Decodes the fetched
//               instruction, reads operands from the register file in the
//               same cycle and holds ALU op/operands, control flags and the
//               immediate for execute behind a valid/ready handshake.
// Ports       : clk, rst_n (async, active low), flush
//               if_valid/if_ready/if_instr/if_pc     - fetch side
//               rf_rs1_addr/rf_rs2_addr, rf_rs*_data - register file reads
//               ex_valid/ex_ready and ex_* fields     - execute side
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [3:0]      ex_alu_ctrl,
    output logic [XLEN-1:0] ex_data_x,
    output logic [XLEN-1:0] ex_data_y,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_we,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic [2:0]      ex_funct3,
    output logic            ex_illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_shamt_rs2;
    logic [XLEN-1:0] w_shamt_imm;
    logic            w_legal;
    logic            w_capture;
    dec_t            w_dec;

    logic            r_valid;
    dec_t            r_dec;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;

    assign w_opcode    = if_instr[6:0];
    assign w_rd        = if_instr[11:7];
    assign w_funct3    = if_instr[14:12];
    assign w_funct7    = if_instr[31:25];
    assign rf_rs1_addr = if_instr[19:15];
    assign rf_rs2_addr = if_instr[24:20];

    // The ALU shifts by the whole y operand, so shift amounts are trimmed here
    assign w_shamt_rs2 = {27'b0, rf_rs2_data[4:0]};
    assign w_shamt_imm = {27'b0, if_instr[24:20]};

    assign if_ready  = !r_valid || ex_ready;
    assign w_capture = if_valid && if_ready && !flush;

    imm_gen u_imm_gen (
        .instr (if_instr[31:7]),
        .imm_i (w_imm_i),
        .imm_s (w_imm_s),
        .imm_b (w_imm_b),
        .imm_u (w_imm_u),
        .imm_j (w_imm_j)
    );

    always_comb begin
        w_dec   = '0;
        w_legal = 1'b1;
        case (w_opcode)
            OPC_OP: begin
                w_dec.data_x = rf_rs1_data;
                w_dec.data_y = rf_rs2_data;
                w_dec.we     = 1'b1;
                if (w_funct7 == 7'b0000000)
                    w_dec.alu_ctrl = alu_from_f3(w_funct3);
                else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000)
                    w_dec.alu_ctrl = ALU_SUB;
                else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101)
                    w_dec.alu_ctrl = ALU_SRA;
                else
                    w_legal = 1'b0;
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                    w_dec.data_y = w_shamt_rs2;
            end
            OPC_OPIMM: begin
                w_dec.data_x   = rf_rs1_data;
                w_dec.data_y   = w_imm_i;
                w_dec.imm      = w_imm_i;
                w_dec.we       = 1'b1;
                w_dec.alu_ctrl = alu_from_f3(w_funct3);
                if (w_funct3 == 3'b001) begin
                    w_dec.data_y = w_shamt_imm;
                    if (w_funct7 != 7'b0000000)
                        w_legal = 1'b0;
                end else if (w_funct3 == 3'b101) begin
                    // imm[11:5] selects logical vs arithmetic right shift
                    w_dec.data_y = w_shamt_imm;
                    if (w_funct7 == 7'b0100000)
                        w_dec.alu_ctrl = ALU_SRA;
                    else if (w_funct7 != 7'b0000000)
                        w_legal = 1'b0;
                end
            end
            OPC_LUI: begin
                w_dec.data_y = w_imm_u;
                w_dec.imm    = w_imm_u;
                w_dec.we     = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.data_x = if_pc;
                w_dec.data_y = w_imm_u;
                w_dec.imm    = w_imm_u;
                w_dec.we     = 1'b1;
            end
            OPC_LOAD: begin
                w_dec.data_x = rf_rs1_data;
                w_dec.data_y = w_imm_i;
                w_dec.imm    = w_imm_i;
                w_dec.mem_rd = 1'b1;
                w_dec.we     = 1'b1;
            end
            OPC_STORE: begin
                w_dec.data_x     = rf_rs1_data;
                w_dec.data_y     = w_imm_s;
                w_dec.imm        = w_imm_s;
                w_dec.store_data = rf_rs2_data;
                w_dec.mem_wr     = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU produces the link address; execute forms the target
                w_dec.data_x = if_pc;
                w_dec.data_y = 32'd4;
                w_dec.imm    = (w_opcode == OPC_JAL) ? w_imm_j : w_imm_i;
                w_dec.jump   = 1'b1;
                w_dec.we     = 1'b1;
            end
            OPC_BRANCH: begin
                w_dec.data_x = rf_rs1_data;
                w_dec.data_y = rf_rs2_data;
                w_dec.imm    = w_imm_b;
                w_dec.branch = 1'b1;
                case (w_funct3[2:1])
                    2'b00:   w_dec.alu_ctrl = ALU_SUB;
                    2'b10:   w_dec.alu_ctrl = ALU_SLT;
                    2'b11:   w_dec.alu_ctrl = ALU_SLTU;
                    default: w_legal        = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase

        if (!w_legal) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end
        if (w_rd == 5'd0)
            w_dec.we = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_dec    <= '0;
            r_pc     <= RESET_PC;
            r_rd     <= 5'd0;
            r_funct3 <= 3'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid  <= 1'b1;
            r_dec    <= w_dec;
            r_pc     <= if_pc;
            r_rd     <= w_rd;
            r_funct3 <= w_funct3;
        end else if (ex_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_alu_ctrl   = r_dec.alu_ctrl;
    assign ex_data_x     = r_dec.data_x;
    assign ex_data_y     = r_dec.data_y;
    assign ex_imm        = r_dec.imm;
    assign ex_store_data = r_dec.store_data;
    assign ex_pc         = r_pc;
    assign ex_rd         = r_rd;
    assign ex_we         = r_dec.we;
    assign ex_mem_rd     = r_dec.mem_rd;
    assign ex_mem_wr     = r_dec.mem_wr;
    assign ex_branch     = r_dec.branch;
    assign ex_jump       = r_dec.jump;
    assign ex_funct3     = r_funct3;
    assign ex_illegal    = r_dec.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Self-checking bench for id_stage: directed scenarios followed
//               by randomized traffic compared against a behavioural decoder
//               and handshake model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                           A_SLTU = 4'd4, A_SRA = 4'd7;

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] imm;
        logic [31:0] sd;
        logic        we;
        logic        mrd;
        logic        mwr;
        logic        br;
        logic        jmp;
        logic        ill;
    } exp_t;

    logic        clk, rst_n, flush, if_valid, if_ready, ex_valid, ex_ready;
    logic [31:0] if_instr, if_pc, rf_rs1_data, rf_rs2_data;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr, ex_rd;
    logic [3:0]  ex_alu_ctrl;
    logic [31:0] ex_data_x, ex_data_y, ex_imm, ex_store_data, ex_pc;
    logic        ex_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal;
    logic [2:0]  ex_funct3;

    logic [31:0] regs [32];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference state of the held entry
    logic        m_valid;
    exp_t        m_e;
    logic [31:0] m_pc;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;

    int base_op [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_data_x(ex_data_x), .ex_data_y(ex_data_y), .ex_imm(ex_imm),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_we(ex_we),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file lives in the bench and is addressed by the DUT
    always_comb begin
        rf_rs1_data = regs[rf_rs1_addr];
        rf_rs2_data = regs[rf_rs2_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Behavioural decoder: immediates built arithmetically from the word
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic        ok;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] ii, is_, ib, iu, ij;
        e  = '0;
        ok = 1'b1;
        f7 = ins[31:25];
        f3 = ins[14:12];
        ii  = 32'($signed(ins) >>> 20);
        is_ = (ii & ~32'd31) | 32'(ins[11:7]);
        ib  = (32'($signed(ins) >>> 19) & 32'hFFFF_F000) | (32'(ins[7]) << 11)
            | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        iu  = ins & 32'hFFFF_F000;
        ij  = (32'($signed(ins) >>> 11) & 32'hFFF0_0000) | (ins & 32'h000F_F000)
            | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        case (ins[6:0])
            7'h33: begin
                e.x = a; e.y = b; e.we = 1'b1;
                if (f7 == 7'h00)                  e.alu = 4'(base_op[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) e.alu = A_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) e.alu = A_SRA;
                else                              ok = 1'b0;
                if (f3 == 3'd1 || f3 == 3'd5) e.y = b % 32;
            end
            7'h13: begin
                e.x = a; e.y = ii; e.imm = ii; e.we = 1'b1; e.alu = 4'(base_op[f3]);
                if (f3 == 3'd1) begin
                    e.y = 32'(ins[24:20]);
                    ok  = (f7 == 7'h00);
                end else if (f3 == 3'd5) begin
                    e.y = 32'(ins[24:20]);
                    if (f7 == 7'h20)      e.alu = A_SRA;
                    else if (f7 != 7'h00) ok = 1'b0;
                end
            end
            7'h37: begin e.y = iu; e.imm = iu; e.we = 1'b1; end
            7'h17: begin e.x = pc; e.y = iu; e.imm = iu; e.we = 1'b1; end
            7'h03: begin e.x = a; e.y = ii; e.imm = ii; e.mrd = 1'b1; e.we = 1'b1; end
            7'h23: begin e.x = a; e.y = is_; e.imm = is_; e.sd = b; e.mwr = 1'b1; end
            7'h6F: begin e.x = pc; e.y = 32'd4; e.imm = ij; e.jmp = 1'b1; e.we = 1'b1; end
            7'h67: begin e.x = pc; e.y = 32'd4; e.imm = ii; e.jmp = 1'b1; e.we = 1'b1; end
            7'h63: begin
                e.x = a; e.y = b; e.imm = ib; e.br = 1'b1;
                if (f3 <= 3'd1)      e.alu = A_SUB;
                else if (f3 <= 3'd3) ok = 1'b0;
                else if (f3 <= 3'd5) e.alu = A_SLT;
                else                 e.alu = A_SLTU;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e     = '0;
            e.ill = 1'b1;
        end
        if (ins[11:7] == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    task automatic check_outputs();
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        if (m_valid) begin
            chk("alu_ctrl", 32'(ex_alu_ctrl), 32'(m_e.alu));
            chk("data_x", ex_data_x, m_e.x);
            chk("data_y", ex_data_y, m_e.y);
            chk("imm", ex_imm, m_e.imm);
            chk("store_data", ex_store_data, m_e.sd);
            chk("pc", ex_pc, m_pc);
            chk("rd", 32'(ex_rd), 32'(m_rd));
            chk("funct3", 32'(ex_funct3), 32'(m_f3));
            chk("we", 32'(ex_we), 32'(m_e.we));
            chk("mem_rd", 32'(ex_mem_rd), 32'(m_e.mrd));
            chk("mem_wr", 32'(ex_mem_wr), 32'(m_e.mwr));
            chk("branch", 32'(ex_branch), 32'(m_e.br));
            chk("jump", 32'(ex_jump), 32'(m_e.jmp));
            chk("illegal", 32'(ex_illegal), 32'(m_e.ill));
        end
    endtask

    // One clock with inputs already applied; updates the model, then checks
    task automatic tick();
        logic cap;
        exp_t nxt;
        #1;
        chk("if_ready", 32'(if_ready), 32'(!m_valid || ex_ready));
        chk("rs1_addr", 32'(rf_rs1_addr), 32'(if_instr[19:15]));
        chk("rs2_addr", 32'(rf_rs2_addr), 32'(if_instr[24:20]));
        cap = if_valid && (!m_valid || ex_ready) && !flush;
        nxt = model(if_instr, if_pc, regs[if_instr[19:15]], regs[if_instr[24:20]]);
        @(posedge clk);
        #1;
        if (flush) m_valid = 1'b0;
        else if (cap) begin
            m_valid = 1'b1;
            m_e     = nxt;
            m_pc    = if_pc;
            m_rd    = if_instr[11:7];
            m_f3    = if_instr[14:12];
        end else if (ex_ready) m_valid = 1'b0;
        check_outputs();
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic v, input logic rdy, input logic fl);
        if_instr = ins;
        if_pc    = pc;
        if_valid = v;
        ex_ready = rdy;
        flush    = fl;
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0:  w[6:0] = 7'h33;
            1:  w[6:0] = 7'h13;
            2:  w[6:0] = 7'h37;
            3:  w[6:0] = 7'h17;
            4:  w[6:0] = 7'h03;
            5:  w[6:0] = 7'h23;
            6:  w[6:0] = 7'h6F;
            7:  w[6:0] = 7'h67;
            8:  w[6:0] = 7'h63;
            9:  w[6:0] = {5'b01100, 2'($urandom_range(0, 2))};
            default: ;
        endcase
        if (k <= 1 && $urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 7) == 0)
            w[11:7] = 5'd0;
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
        regs[1] = 32'd10;
        regs[2] = 32'd3;
        regs[4] = 32'h0000_0123;
        rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b0;
        if_instr = 32'h0000_0013; if_pc = 32'd0;
        m_valid = 1'b0; m_e = '0; m_pc = RST_PC; m_rd = 5'd0; m_f3 = 3'd0;

        // Reset state
        #12;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        chk("rst_pc", ex_pc, RST_PC);
        chk("rst_alu", 32'(ex_alu_ctrl), 32'd0);
        chk("rst_x", ex_data_x, 32'd0);
        chk("rst_y", ex_data_y, 32'd0);
        chk("rst_flags", 32'({ex_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADDI x1,x0,5
        drive(32'h0050_0093, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_y", ex_data_y, 32'd5);
        chk("addi_rd", 32'(ex_rd), 32'd1);
        // SUB x3,x1,x2
        drive(32'h4020_81B3, 32'h0000_0104, 1'b1, 1'b1, 1'b0);
        chk("sub_alu", 32'(ex_alu_ctrl), 32'd1);
        chk("sub_x", ex_data_x, 32'd10);
        chk("sub_y", ex_data_y, 32'd3);
        // SRAI x5,x6,3
        drive(32'h4033_5293, 32'h0000_0108, 1'b1, 1'b1, 1'b0);
        chk("srai_alu", 32'(ex_alu_ctrl), 32'd7);
        chk("srai_y", ex_data_y, 32'd3);
        // SLL x8,x1,x4 with x4=0x123
        drive(32'h0040_9433, 32'h0000_010C, 1'b1, 1'b1, 1'b0);
        chk("sll_alu", 32'(ex_alu_ctrl), 32'd2);
        chk("sll_y", ex_data_y, 32'd3);
        // LUI x7,0x12345
        drive(32'h1234_53B7, 32'h0000_0110, 1'b1, 1'b1, 1'b0);
        chk("lui_x", ex_data_x, 32'd0);
        chk("lui_y", ex_data_y, 32'h1234_5000);
        // ADDI x0,x0,1 -> no writeback
        drive(32'h0010_0013, 32'h0000_0114, 1'b1, 1'b1, 1'b0);
        chk("addi_x0_we", 32'(ex_we), 32'd0);

        // Stall three cycles with a new instruction waiting
        drive(32'h0020_8233, 32'h0000_0118, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_A083, 32'h0000_011C, 1'b1, 1'b0, 1'b0);
            chk("stall_if_ready", 32'(if_ready), 32'd0);
            chk("stall_pc", ex_pc, 32'h0000_0118);
        end
        // Release: back-to-back captures
        drive(32'h0000_A083, 32'h0000_011C, 1'b1, 1'b1, 1'b0);
        chk("b2b_pc0", ex_pc, 32'h0000_011C);
        drive(32'h0010_A023, 32'h0000_0120, 1'b1, 1'b1, 1'b0);
        chk("b2b_valid", 32'(ex_valid), 32'd1);
        chk("b2b_pc1", ex_pc, 32'h0000_0120);

        // Illegal word
        drive(32'hFFFF_FFFF, 32'h0000_0124, 1'b1, 1'b1, 1'b0);
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_we", 32'(ex_we), 32'd0);
        // Flush together with an incoming instruction
        drive(32'h0050_0093, 32'h0000_0128, 1'b1, 1'b1, 1'b1);
        chk("flush_valid", 32'(ex_valid), 32'd0);

        // Asynchronous reset in the middle of a stall
        drive(32'h0050_0093, 32'h0000_012C, 1'b1, 1'b1, 1'b0);
        drive(32'h0050_0093, 32'h0000_0130, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_pc", ex_pc, RST_PC);
        chk("arst_if_ready", 32'(if_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            regs[$urandom_range(1, 31)] = $urandom;
            drive(rand_instr(), {$urandom, 2'b00} , ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
